// File: rtl/count_job_scheduler.sv
// rtl/count_job_scheduler.sv - query FIFO and launch/collect scheduler for the count engine
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset (shared with the engine)
//   q_valid/q_ready   query submit handshake, q_x carries the target value
//   r_valid/r_ready   result handshake, r_x echoes the query, r_freq is the engine count
//   eng_x/eng_go      drive the engine's x and go pins
//   eng_done/eng_freq engine completion flag and count
//   busy              a job is in flight or queries are waiting
//   pending           queued queries, not counting the one in flight

module count_job_scheduler #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [SIZE-1:0]        q_x,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [SIZE-1:0]        r_x,
  output logic [SIZE-1:0]        r_freq,
  output logic [SIZE-1:0]        eng_x,
  output logic                   eng_go,
  input  logic                   eng_done,
  input  logic [SIZE-1:0]        eng_freq,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  logic [1:0]      state;
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            launch;

  // q_ready looks only at the registered count, so a full FIFO never
  // accepts in the same cycle that a launch frees a slot.
  assign q_ready = (count < FULL);
  assign push    = q_valid && q_ready;

  // A done level left over from the previous job holds off the next launch.
  assign launch  = (state == IDLE) && (count != '0) && !eng_done;

  assign pending = count;
  assign busy    = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= q_x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      eng_x   <= '0;
      eng_go  <= 1'b0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_freq  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            eng_x  <= mem[rd_ptr];
            eng_go <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (eng_done) begin
            r_x     <= eng_x;
            r_freq  <= eng_freq;
            eng_go  <= 1'b0;
            r_valid <= 1'b1;
            state   <= RESULT;
          end
        end
        RESULT: begin
          // The result is held until taken; no new job starts meanwhile.
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          eng_go  <= 1'b0;
          r_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_job_scheduler.sv
// tb/tb_count_job_scheduler.sv - self-checking bench for count_job_scheduler

module tb_count_job_scheduler;

  logic       clk;
  logic       reset;
  logic       q_valid;
  logic       q_ready;
  logic [7:0] q_x;
  logic       r_valid;
  logic       r_ready;
  logic [7:0] r_x;
  logic [7:0] r_freq;
  logic [7:0] eng_x;
  logic       eng_go;
  logic       eng_done;
  logic [7:0] eng_freq;
  logic       busy;
  logic [2:0] pending;

  count_job_scheduler #(.SIZE(8), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_x      (q_x),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_x      (r_x),
    .r_freq   (r_freq),
    .eng_x    (eng_x),
    .eng_go   (eng_go),
    .eng_done (eng_done),
    .eng_freq (eng_freq),
    .busy     (busy),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stand-in: done rises m_lat+1 edges after go is seen, stays high
  // until go has dropped, then lingers m_hold_cfg extra cycles.
  logic       use_model;
  logic       tbl_done;
  logic [7:0] tbl_freq;
  logic       m_done;
  logic [7:0] m_freq;
  logic [7:0] m_cnt;
  logic [7:0] m_lat;
  logic       m_never;
  logic       m_const_en;
  logic [7:0] m_const;
  logic [7:0] m_xor;
  logic [3:0] m_hold_cfg;
  logic [3:0] m_hold;

  assign eng_done = use_model ? m_done : tbl_done;
  assign eng_freq = use_model ? m_freq : tbl_freq;

  always @(posedge clk) begin
    if (reset || !use_model) begin
      m_cnt  <= 8'd0;
      m_done <= 1'b0;
      m_hold <= 4'd0;
      m_freq <= 8'd0;
    end else if (eng_go && !m_done) begin
      if (!m_never && m_cnt == m_lat) begin
        m_done <= 1'b1;
        m_freq <= m_const_en ? m_const : (eng_x ^ m_xor);
        m_hold <= m_hold_cfg;
      end
      m_cnt <= m_cnt + 8'd1;
    end else if (!eng_go) begin
      m_cnt <= 8'd0;
      if (m_hold != 4'd0) m_hold <= m_hold - 4'd1;
      else m_done <= 1'b0;
    end
  end

  int n_checks;
  int n_errors;
  logic prev_done;
  logic prev_go;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    prev_done = eng_done;
    prev_go   = eng_go;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    q_valid = 1'b0;
    r_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       qv;
    logic [7:0] qx;
    logic       rr;
    logic       ed;
    logic [7:0] ef;
    logic       qr;
    logic       rv;
    logic [7:0] rx;
    logic [7:0] rf;
    logic [7:0] ex;
    logic       eg;
    logic       bz;
    logic [2:0] pd;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic qv, input logic [7:0] qx, input logic rr,
                     input logic ed, input logic [7:0] ef, input logic qr, input logic rv,
                     input logic [7:0] rx, input logic [7:0] rf, input logic [7:0] ex,
                     input logic eg, input logic bz, input logic [2:0] pd);
    vec_t v;
    v.rst = rst; v.qv = qv; v.qx = qx; v.rr = rr; v.ed = ed; v.ef = ef;
    v.qr = qr; v.rv = rv; v.rx = rx; v.rf = rf; v.ex = ex; v.eg = eg; v.bz = bz; v.pd = pd;
    tbl.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_x [3];
    logic [7:0] got_x [3];
    logic [7:0] got_f [3];
    logic [7:0] cap_x;
    logic [7:0] cap_f;
    logic [2:0] cap_p;
    int got;
    int acc;
    int bad;
    int pulses;
    int go_cnt;
    int launches;
    int pushed;
    logic prev_rv;
    logic saw_stall;
    logic found;

    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    q_valid    = 1'b0;
    q_x        = 8'h00;
    r_ready    = 1'b0;
    use_model  = 1'b0;
    tbl_done   = 1'b0;
    tbl_freq   = 8'h00;
    m_lat      = 8'd9;
    m_never    = 1'b0;
    m_const_en = 1'b0;
    m_const    = 8'h00;
    m_xor      = 8'h00;
    m_hold_cfg = 4'd0;
    prev_done  = 1'b0;
    prev_go    = 1'b0;

    // Reset with random inputs, then idle with no queries.
    for (int i = 0; i < 3; i++) begin
      q_valid  = 1'($urandom_range(0, 1));
      q_x      = 8'($urandom_range(0, 255));
      r_ready  = 1'($urandom_range(0, 1));
      tbl_done = 1'($urandom_range(0, 1));
      tbl_freq = 8'($urandom_range(0, 255));
      step();
      chk($sformatf("rst%0d q_ready", i), 32'(q_ready), 32'd1);
      chk($sformatf("rst%0d r_valid", i), 32'(r_valid), 32'd0);
      chk($sformatf("rst%0d r_x", i), 32'(r_x), 32'd0);
      chk($sformatf("rst%0d r_freq", i), 32'(r_freq), 32'd0);
      chk($sformatf("rst%0d eng_x", i), 32'(eng_x), 32'd0);
      chk($sformatf("rst%0d eng_go", i), 32'(eng_go), 32'd0);
      chk($sformatf("rst%0d busy", i), 32'(busy), 32'd0);
      chk($sformatf("rst%0d pending", i), 32'(pending), 32'd0);
    end
    reset    = 1'b0;
    q_valid  = 1'b0;
    tbl_done = 1'b0;
    r_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
    end

    // Per-cycle vectors with the done pin driven directly.
    //   rst   qv    qx     rr    ed    ef      qr    rv    rx     rf     ex     eg    bz    pd
    row(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    row(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h05, 1'b1, 1'b1, 3'd0);
    row(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h05, 1'b1, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b1, 1'b1, 8'h05, 8'hF3, 8'h05, 1'b0, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h05, 8'hF3, 8'h05, 1'b0, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'hF3, 8'h05, 1'b0, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h05, 8'hF3, 8'h05, 1'b0, 1'b1, 3'd1);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'hF3, 8'h06, 1'b1, 1'b1, 3'd0);
    row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 8'hF3, 8'h06, 1'b1, 1'b1, 3'd0);
    row(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 8'h06, 8'h12, 8'h06, 1'b0, 1'b1, 3'd0);
    row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 8'h12, 8'h06, 1'b0, 1'b0, 3'd0);
    row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 8'h12, 8'h06, 1'b0, 1'b0, 3'd0);
    row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);

    foreach (tbl[i]) begin
      reset    = tbl[i].rst;
      q_valid  = tbl[i].qv;
      q_x      = tbl[i].qx;
      r_ready  = tbl[i].rr;
      tbl_done = tbl[i].ed;
      tbl_freq = tbl[i].ef;
      step();
      chk($sformatf("row%0d q_ready", i), 32'(q_ready), 32'(tbl[i].qr));
      chk($sformatf("row%0d r_valid", i), 32'(r_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d r_x", i), 32'(r_x), 32'(tbl[i].rx));
      chk($sformatf("row%0d r_freq", i), 32'(r_freq), 32'(tbl[i].rf));
      chk($sformatf("row%0d eng_x", i), 32'(eng_x), 32'(tbl[i].ex));
      chk($sformatf("row%0d eng_go", i), 32'(eng_go), 32'(tbl[i].eg));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].pd));
    end
    reset    = 1'b0;
    tbl_done = 1'b0;

    // Single job through the engine model.
    use_model  = 1'b1;
    m_lat      = 8'd9;
    m_const_en = 1'b1;
    m_const    = 8'hF3;
    do_reset();
    q_valid = 1'b1;
    q_x     = 8'h05;
    r_ready = 1'b1;
    step();
    chk("single pending_after_accept", 32'(pending), 32'd1);
    chk("single go_before_launch", 32'(eng_go), 32'd0);
    q_valid = 1'b0;
    step();
    chk("single go_rise", 32'(eng_go), 32'd1);
    chk("single eng_x", 32'(eng_x), 32'h05);
    go_cnt  = 1;
    pulses  = 0;
    bad     = 0;
    prev_rv = r_valid;
    for (int c = 0; c < 40; c++) begin
      step();
      if (eng_go) begin
        go_cnt++;
        if (eng_x !== 8'h05) bad++;
      end
      if (r_valid && !prev_rv) begin
        pulses++;
        chk("single r_x", 32'(r_x), 32'h05);
        chk("single r_freq", 32'(r_freq), 32'hF3);
        chk("single go_fall_on_done", 32'(eng_go), 32'd0);
        chk("single done_seen", 32'(prev_done), 32'd1);
      end
      prev_rv = r_valid;
    end
    chk("single eng_x_stable", 32'(bad), 32'd0);
    chk("single go_cycles", 32'(go_cnt), 32'd11);
    chk("single r_valid_pulses", 32'(pulses), 32'd1);

    // Capacity: the engine never finishes.
    m_const_en = 1'b0;
    m_never    = 1'b1;
    do_reset();
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      q_valid = 1'b1;
      q_x     = 8'(i);
      if (q_ready) acc++;
      step();
    end
    chk("cap accepted", 32'(acc), 32'd5);
    chk("cap q_ready", 32'(q_ready), 32'd0);
    chk("cap pending", 32'(pending), 32'd4);
    q_x = 8'h77;
    step();
    step();
    chk("cap pending_hold", 32'(pending), 32'd4);
    chk("cap eng_x_first", 32'(eng_x), 32'h01);
    chk("cap eng_go", 32'(eng_go), 32'd1);
    q_valid = 1'b0;

    // Ordering with freq = x ^ 0xAA.
    m_never    = 1'b0;
    m_lat      = 8'd2;
    m_xor      = 8'hAA;
    m_hold_cfg = 4'd0;
    do_reset();
    r_ready  = 1'b1;
    exp_x[0] = 8'h00;
    exp_x[1] = 8'hFF;
    exp_x[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      q_valid = 1'b1;
      q_x     = exp_x[i];
      step();
    end
    q_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && got < 3; c++) begin
      if (r_valid) begin
        got_x[got] = r_x;
        got_f[got] = r_freq;
        got++;
      end
      step();
    end
    chk("order count", 32'(got), 32'd3);
    chk("order r_x0", 32'(got_x[0]), 32'h00);
    chk("order r_f0", 32'(got_f[0]), 32'hAA);
    chk("order r_x1", 32'(got_x[1]), 32'hFF);
    chk("order r_f1", 32'(got_f[1]), 32'h55);
    chk("order r_x2", 32'(got_x[2]), 32'h11);
    chk("order r_f2", 32'(got_f[2]), 32'hBB);

    // Backpressure: result held for 20 cycles with r_ready low.
    do_reset();
    q_valid = 1'b1;
    q_x     = 8'h33;
    step();
    q_x     = 8'h44;
    step();
    q_valid = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (r_valid) found = 1'b1;
      else step();
    end
    chk("bp result_seen", 32'(found), 32'd1);
    cap_x = r_x;
    cap_f = r_freq;
    cap_p = pending;
    chk("bp r_x", 32'(cap_x), 32'h33);
    chk("bp r_freq", 32'(cap_f), 32'h99);
    chk("bp pending", 32'(cap_p), 32'd1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (r_valid !== 1'b1 || r_x !== cap_x || r_freq !== cap_f ||
          eng_go !== 1'b0 || pending !== cap_p) bad++;
    end
    chk("bp stable_cycles_bad", 32'(bad), 32'd0);
    r_ready = 1'b1;
    step();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (r_valid) found = 1'b1;
      else step();
    end
    chk("bp second_seen", 32'(found), 32'd1);
    chk("bp second_r_x", 32'(r_x), 32'h44);
    chk("bp second_r_freq", 32'(r_freq), 32'hEE);

    // Done held high for 3 extra cycles after go drops.
    m_hold_cfg = 4'd3;
    do_reset();
    r_ready   = 1'b1;
    pushed    = 0;
    launches  = 0;
    got       = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (pushed < 2) begin
        q_valid = 1'b1;
        q_x     = (pushed == 0) ? 8'h21 : 8'h22;
      end else begin
        q_valid = 1'b0;
      end
      if (q_valid && q_ready) pushed++;
      step();
      if (eng_go && !prev_go) begin
        launches++;
        chk($sformatf("hold launch%0d_done_low", launches), 32'(prev_done), 32'd0);
      end
      if (!r_valid && !eng_go && eng_done && pending != 3'd0) saw_stall = 1'b1;
      if (r_valid && got < 3) begin
        got_x[got] = r_x;
        got_f[got] = r_freq;
        got++;
      end
    end
    q_valid = 1'b0;
    chk("hold launches", 32'(launches), 32'd2);
    chk("hold stall_seen", 32'(saw_stall), 32'd1);
    chk("hold results", 32'(got), 32'd2);
    chk("hold r_f0", 32'(got_f[0]), 32'h8B);
    chk("hold r_f1", 32'(got_f[1]), 32'h88);
    m_hold_cfg = 4'd0;

    // Reset in the middle of a job.
    m_never = 1'b1;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      q_valid = 1'b1;
      q_x     = 8'(i);
      step();
    end
    q_valid = 1'b0;
    step();
    step();
    chk("midrst go_before", 32'(eng_go), 32'd1);
    reset   = 1'b1;
    m_never = 1'b0;
    m_lat   = 8'd2;
    step();
    chk("midrst eng_go", 32'(eng_go), 32'd0);
    chk("midrst pending", 32'(pending), 32'd0);
    chk("midrst r_valid", 32'(r_valid), 32'd0);
    reset   = 1'b0;
    r_ready = 1'b1;
    bad     = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (r_valid || eng_go) bad++;
    end
    chk("midrst no_stale", 32'(bad), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
